// File: rtl/ucie_ctl_adapter_rdi_data_xfer_if.sv
// RDI mainband data bundle between the adapter (LP, master) and the PHY (PL, slave).
// Handshakes: a TX beat transfers on a rising clock edge where lp_valid && pl_trdy. lp_data
// is held stable until that edge. pl_valid/pl_data is a one-beat push with no backpressure.
interface ucie_ctl_adapter_rdi_data_xfer_if #(
  parameter int NBYTES = 8
);
  logic                  lp_irdy;
  logic                  lp_valid;
  logic [NBYTES*8-1:0]   lp_data;
  logic                  pl_trdy;
  logic                  pl_valid;
  logic [NBYTES*8-1:0]   pl_data;

  modport master (
    output lp_irdy, lp_valid, lp_data,
    input  pl_trdy, pl_valid, pl_data
  );

  modport slave (
    input  lp_irdy, lp_valid, lp_data,
    output pl_trdy, pl_valid, pl_data
  );
endinterface

// File: rtl/ucie_ctl_adapter_rdi_data_xfer.sv
// Adapter-side RDI data path: TX FIFO toward the PHY plus a registered RX capture port.
// Optional beat counters are enabled with `define UCIE_CTL_ADP_XFER_CNT_EN.
module ucie_ctl_adapter_rdi_data_xfer #(
  parameter  int NBYTES = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int DW     = NBYTES * 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [DW-1:0] i_tx_data,
  input  logic          i_tx_valid,
  output logic          o_tx_ready,
  output logic [AW:0]   o_fifo_level,
  ucie_ctl_adapter_rdi_data_xfer_if.master rdi,
  output logic [DW-1:0] o_rx_data,
  output logic          o_rx_valid,
  output logic [15:0]   o_tx_cnt,
  output logic [15:0]   o_rx_cnt,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          full, empty, active;
  logic          push, pop, rx_cap;
  logic [DW-1:0] rx_data_q;
  logic          rx_valid_q;

  // i_flush outranks i_enable from every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else if (i_flush) begin
      state_q <= ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:   if (i_enable)  state_q <= ST_ACTIVE;
        ST_ACTIVE: if (!i_enable) state_q <= ST_IDLE;
        ST_FLUSH:  state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign active = (state_q == ST_ACTIVE);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty  = (wptr_q == rptr_q);

  assign o_tx_ready   = !full && (state_q != ST_FLUSH);
  assign o_fifo_level = wptr_q - rptr_q;

  assign push = i_tx_valid && o_tx_ready;
  assign pop  = rdi.lp_valid && rdi.pl_trdy;

  // A flush discards everything, including a push or pop in the same cycle.
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= i_tx_data;
  end

  // Outputs decode only registered state and pointers, so pl_trdy never reaches them.
  assign rdi.lp_irdy  = active;
  assign rdi.lp_valid = active && !empty;
  assign rdi.lp_data  = (active && !empty) ? mem_q[rptr_q[AW-1:0]] : '0;

  assign rx_cap = active && rdi.pl_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= rx_cap;
      if (rx_cap) rx_data_q <= rdi.pl_data;
    end
  end

  assign o_rx_valid  = rx_valid_q;
  assign o_rx_data   = rx_data_q;
  assign o_dbg_state = state_q;

`ifdef UCIE_CTL_ADP_XFER_CNT_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;

  // Saturating; flush leaves them untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (pop && (tx_cnt_q != 16'hFFFF))    tx_cnt_q <= tx_cnt_q + 16'd1;
      if (rx_cap && (rx_cnt_q != 16'hFFFF)) rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign o_tx_cnt = tx_cnt_q;
  assign o_rx_cnt = rx_cnt_q;
`else
  assign o_tx_cnt = '0;
  assign o_rx_cnt = '0;
`endif

endmodule

// File: tb/tb_ucie_ctl_adapter_rdi_data_xfer.sv
// Self-checking bench for ucie_ctl_adapter_rdi_data_xfer: TX scoreboard plus directed RX/flush cases.
module tb_ucie_ctl_adapter_rdi_data_xfer;
  localparam int NBYTES = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = NBYTES * 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, flush, tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic [AW:0]  fifo_level;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic [15:0]  tx_cnt, rx_cnt;
  logic [1:0]   dbg_state;

  ucie_ctl_adapter_rdi_data_xfer_if #(.NBYTES(NBYTES)) rdi_if ();

  ucie_ctl_adapter_rdi_data_xfer #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_flush      (flush),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_fifo_level (fifo_level),
    .rdi          (rdi_if),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_tx_cnt     (tx_cnt),
    .o_rx_cnt     (rx_cnt),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int beats  = 0;
  int rx_beats = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: model level before updating, then consume beats and record pushes
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", W'(fifo_level), W'(exp_q.size()));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (rdi_if.lp_valid && rdi_if.pl_trdy) begin
          if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            check("lp_data", rdi_if.lp_data, exp_q.pop_front());
            beats++;
          end
        end
        if (tx_valid && tx_ready) exp_q.push_back(tx_data);
      end
    end
  end

  // driver: present one flit and hold it until accepted (bounded)
  task automatic push_beat(input logic [W-1:0] d);
    bit ok = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      ok = tx_ready;
      tick();
      if (ok) break;
    end
    tx_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fifo_level == 0) begin ok = 1; break; end
    end
    check("drain", W'(ok), 1);
    tick();
    check("drain_model", W'(exp_q.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] last_rx;
    int b0;
    rst_n = 1'b0; enable = 0; flush = 0; tx_valid = 0; tx_data = '0;
    rdi_if.pl_trdy = 0; rdi_if.pl_valid = 0; rdi_if.pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", W'(tx_ready), 1);
    check("rst_level",    W'(fifo_level), 0);
    check("rst_irdy",     W'(rdi_if.lp_irdy), 0);
    check("rst_lp_valid", W'(rdi_if.lp_valid), 0);
    check("rst_lp_data",  rdi_if.lp_data, 0);
    check("rst_rx_valid", W'(rx_valid), 0);
    check("rst_rx_data",  rx_data, 0);
    check("rst_cnt",      W'({tx_cnt, rx_cnt}), 0);
    check("rst_state",    W'(dbg_state), 0);
    rst_n = 1'b1;
    tick();

    // 1: four back-to-back beats
    enable = 1; rdi_if.pl_trdy = 1;
    tick();
    @(negedge clk);
    check("t1_irdy", W'(rdi_if.lp_irdy), 1);
    tick();
    b0 = beats;
    for (int i = 1; i <= 4; i++) push_beat(W'(8'h11 * i));
    tick();
    @(negedge clk);
    check("t1_tput", W'(beats - b0), 4);
    check("t1_valid_low", W'(rdi_if.lp_valid), 0);
    check("t1_level", W'(fifo_level), 0);
    tick();

    // 2: pre-load in IDLE past full
    enable = 0;
    tick();
    for (int i = 0; i < 4; i++) push_beat(W'(8'hA0 + i));
    tx_valid = 1; tx_data = W'(8'hA4);
    @(negedge clk);
    check("t2_ready_full", W'(tx_ready), 0);
    check("t2_level4", W'(fifo_level), 4);
    check("t2_idle_valid", W'(rdi_if.lp_valid), 0);
    tick();
    enable = 1;
    push_beat(W'(8'hA4));
    wait_drain();

    // 3: head held under backpressure
    rdi_if.pl_trdy = 0;
    push_beat(W'(8'hAB));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", W'(rdi_if.lp_valid), 1);
      check("t3_hold_data", rdi_if.lp_data, W'(8'hAB));
      tick();
    end
    rdi_if.pl_trdy = 1;
    tick();
    @(negedge clk);
    check("t3_popped", W'(fifo_level), 0);
    tick();

    // 4: disable with two queued, then resume
    rdi_if.pl_trdy = 0;
    push_beat(W'(8'hC1));
    push_beat(W'(8'hC2));
    enable = 0;
    tick();
    @(negedge clk);
    check("t4_irdy", W'(rdi_if.lp_irdy), 0);
    check("t4_valid", W'(rdi_if.lp_valid), 0);
    check("t4_data", rdi_if.lp_data, 0);
    check("t4_level", W'(fifo_level), 2);
    tick();
    enable = 1; rdi_if.pl_trdy = 1;
    wait_drain();

    // 5: flush with three queued and a push pending
    enable = 0; rdi_if.pl_trdy = 0;
    tick();
    for (int i = 1; i <= 3; i++) push_beat(W'(8'hD0 + i));
    tx_valid = 1; tx_data = W'(8'hEE); flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    check("t5_state_flush", W'(dbg_state), 2);
    check("t5_ready_flush", W'(tx_ready), 0);
    check("t5_level", W'(fifo_level), 0);
    tick();
    tx_valid = 0;
    @(negedge clk);
    check("t5_state_idle", W'(dbg_state), 0);
    check("t5_level_after", W'(fifo_level), 0);
    tick();

    // 6: RX capture, directed then random
    enable = 1;
    tick();
    last_rx = rx_data;
    for (int i = 0; i < 7; i++) begin
      logic pv;
      logic [W-1:0] pd;
      pv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pd = (i == 0) ? 64'hDEAD_BEEF_0000_0001 : {$urandom, $urandom};
      rdi_if.pl_valid = pv; rdi_if.pl_data = pd;
      tick();
      rdi_if.pl_valid = 0; rdi_if.pl_data = {$urandom, $urandom};
      if (pv) begin last_rx = pd; rx_beats++; end
      @(negedge clk);
      check("rx_valid", W'(rx_valid), W'(pv));
      check("rx_data", rx_data, last_rx);
      tick();
      @(negedge clk);
      check("rx_valid_pulse", W'(rx_valid), 0);
      check("rx_data_hold", rx_data, last_rx);
      tick();
    end

    // 7: random TX traffic through the scoreboard
    for (int c = 0; c < 200; c++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = {$urandom, $urandom};
      rdi_if.pl_trdy = 1'($urandom_range(0, 1));
      tick();
    end
    tx_valid = 0; rdi_if.pl_trdy = 1;
    wait_drain();

    @(negedge clk);
`ifdef UCIE_CTL_ADP_XFER_CNT_EN
    check("tx_cnt", W'(tx_cnt), W'(beats));
    check("rx_cnt", W'(rx_cnt), W'(rx_beats));
`else
    check("tx_cnt", W'(tx_cnt), 0);
    check("rx_cnt", W'(rx_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
